// File: rtl/traffic_gen_pkg.sv
// Shared constants and scheduler state encoding for the traffic generator
// and its C2H queue scheduler.
package traffic_gen_pkg;
  localparam int TM_DSC_BITS = 16;
  localparam int QID_W       = 11;

  typedef enum logic [2:0] {IDLE, PICK, ISSUE, WAIT, DONE} sched_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of eligible at or after ptr, wrapping
// modulo MAX_Q. Purely combinational.
module rr_pick #(
  parameter int MAX_Q = 8,
  parameter int PTR_W = 3
) (
  input  logic [MAX_Q-1:0] eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);
  logic [PTR_W-1:0] cand;

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = MAX_Q-1; k >= 0; k--) begin
      cand = ptr + PTR_W'(k);
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/c2h_queue_sched.sv
// Per-queue C2H credit tracker and round-robin packet scheduler feeding
// traffic_gen one request at a time.
module c2h_queue_sched #(
  parameter int MAX_Q       = 8,
  parameter int TM_DSC_BITS = traffic_gen_pkg::TM_DSC_BITS,
  parameter int QID_W       = traffic_gen_pkg::QID_W
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic                   enable,
  input  logic                   soft_clr,
  input  logic [QID_W-1:0]       qid_base,
  input  logic [QID_W-1:0]       num_queue,
  input  logic [31:0]            num_pkt,
  input  logic                   credit_updt,
  input  logic [TM_DSC_BITS-1:0] credit_in,
  input  logic [QID_W-1:0]       credit_qid,
  input  logic [TM_DSC_BITS-1:0] credit_perpkt_in,
  output logic                   issue_valid,
  output logic [QID_W-1:0]       issue_qid,
  input  logic                   issue_ready,
  input  logic                   pkt_done,
  output logic [31:0]            pkt_sent,
  output logic                   sched_busy,
  output logic                   sched_done
);
  import traffic_gen_pkg::*;

  localparam int PTR_W = (MAX_Q > 1) ? $clog2(MAX_Q) : 1;

  logic [MAX_Q-1:0][TM_DSC_BITS-1:0] credit, credit_nxt;
  logic [MAX_Q-1:0]                  eligible;
  logic [QID_W-1:0]                  nq_clamp, upd_idx, idx_inc;
  logic [TM_DSC_BITS-1:0]            perpkt;
  logic                              upd_hit, issue_fire, pick_found;
  logic [PTR_W-1:0]                  rr_ptr, cur_idx, pick_idx, nxt_ptr;
  sched_state_t                      state;

  assign nq_clamp   = (num_queue > QID_W'(MAX_Q)) ? QID_W'(MAX_Q) : num_queue;
  assign perpkt     = (credit_perpkt_in == '0) ? TM_DSC_BITS'(1) : credit_perpkt_in;
  assign upd_idx    = credit_qid - qid_base;
  assign upd_hit    = credit_updt && (credit_qid >= qid_base) && (upd_idx < nq_clamp);
  assign issue_fire = issue_valid & issue_ready;

  // Update and deduction combine before saturation, so a same-cycle hit nets out.
  for (genvar i = 0; i < MAX_Q; i++) begin : g_q
    logic [TM_DSC_BITS:0]   sum, net;
    logic [TM_DSC_BITS-1:0] nxt;
    always_comb begin
      sum = {1'b0, credit[i]};
      if (upd_hit && upd_idx == QID_W'(i)) sum = sum + {1'b0, credit_in};
      net = sum;
      if (issue_fire && cur_idx == PTR_W'(i))
        net = (sum >= {1'b0, perpkt}) ? sum - {1'b0, perpkt} : '0;
      nxt = net[TM_DSC_BITS] ? '1 : net[TM_DSC_BITS-1:0];
    end
    assign credit_nxt[i] = nxt;
    assign eligible[i]   = (QID_W'(i) < nq_clamp) && (credit[i] >= perpkt);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)  credit <= '0;
    else if (soft_clr) credit <= '0;
    else               credit <= credit_nxt;
  end

  rr_pick #(.MAX_Q(MAX_Q), .PTR_W(PTR_W)) u_rr_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Pointer wraps at the active queue count, not at MAX_Q.
  assign idx_inc = QID_W'(cur_idx) + QID_W'(1);
  assign nxt_ptr = (idx_inc >= nq_clamp) ? '0 : PTR_W'(idx_inc);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn || soft_clr) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      pkt_sent    <= '0;
      issue_valid <= 1'b0;
      issue_qid   <= '0;
      sched_busy  <= 1'b0;
      sched_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable && num_queue != '0) begin
          state      <= PICK;
          sched_busy <= 1'b1;
        end
        PICK: if (!enable) begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end else if (pick_found) begin
          cur_idx     <= pick_idx;
          issue_qid   <= qid_base + QID_W'(pick_idx);
          issue_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: if (issue_ready) begin
          issue_valid <= 1'b0;
          rr_ptr      <= nxt_ptr;
          state       <= WAIT;
        end
        WAIT: if (pkt_done) begin
          pkt_sent <= pkt_sent + 32'd1;
          if (num_pkt != '0 && pkt_sent + 32'd1 == num_pkt) begin
            state      <= DONE;
            sched_busy <= 1'b0;
            sched_done <= 1'b1;
          end else if (enable) begin
            state <= PICK;
          end else begin
            state      <= IDLE;
            sched_busy <= 1'b0;
          end
        end
        DONE: if (!enable) begin
          state      <= IDLE;
          sched_done <= 1'b0;
          pkt_sent   <= '0;
        end
        default: begin
          state       <= IDLE;
          issue_valid <= 1'b0;
          sched_busy  <= 1'b0;
          sched_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_c2h_queue_sched.sv
// Bench for c2h_queue_sched: transaction-level credit/RR model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_c2h_queue_sched;
  localparam int MAX_Q = 8;
  localparam int QW    = 11;
  localparam int CMAX  = 65535;

  logic            axi_aclk = 1'b0, axi_aresetn = 1'b0;
  logic            enable = 0, soft_clr = 0, credit_updt = 0, issue_ready = 0, pkt_done = 0;
  logic [QW-1:0]   qid_base = '0, num_queue = '0, credit_qid = '0;
  logic [31:0]     num_pkt = '0;
  logic [15:0]     credit_in = '0, credit_perpkt_in = 16'd1;
  logic            issue_valid, sched_busy, sched_done;
  logic [QW-1:0]   issue_qid;
  logic [31:0]     pkt_sent;

  c2h_queue_sched dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .enable(enable), .soft_clr(soft_clr),
    .qid_base(qid_base), .num_queue(num_queue), .num_pkt(num_pkt),
    .credit_updt(credit_updt), .credit_in(credit_in), .credit_qid(credit_qid),
    .credit_perpkt_in(credit_perpkt_in), .issue_valid(issue_valid), .issue_qid(issue_qid),
    .issue_ready(issue_ready), .pkt_done(pkt_done), .pkt_sent(pkt_sent),
    .sched_busy(sched_busy), .sched_done(sched_done)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks = 0, errors = 0;
  int gen_delay = 10;
  bit chk_lat = 0;
  int iss_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int mc[MAX_Q], prev_mc[MAX_Q];
  int mptr, msent, exp_q, sd;
  bit mdone, minfl, prev_valid;

  function automatic int m_pick(input int c[MAX_Q], input int ptr, input int nq, input int pp);
    for (int k = 0; k < nq; k++) begin
      if (c[(ptr + k) % nq] >= pp) return (ptr + k) % nq;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    foreach (mc[i]) begin mc[i] = 0; prev_mc[i] = 0; end
    mptr = 0; msent = 0; mdone = 0; minfl = 0; prev_valid = 0; exp_q = 0; sd = -1;
  endfunction

  initial begin
    m_reset();
    forever begin
      int nq, pp, d, v;
      bit hs;
      @(negedge axi_aclk);
      if (!axi_aresetn) begin m_reset(); continue; end
      nq = (int'(num_queue) > MAX_Q) ? MAX_Q : int'(num_queue);
      pp = (credit_perpkt_in == 0) ? 1 : int'(credit_perpkt_in);
      if (sd >= 0) sd++;
      chk("pkt_sent", pkt_sent, msent);
      chk("sched_done", {31'd0, sched_done}, {31'd0, mdone});
      for (int i = 0; i < MAX_Q; i++) chk($sformatf("credit[%0d]", i), {16'd0, dut.credit[i]}, mc[i]);
      if (issue_valid && !prev_valid) begin
        exp_q = m_pick(prev_mc, mptr, nq, pp);
        if (exp_q < 0 || minfl || mdone) begin
          checks++; errors++;
          $display("FAIL spurious_issue qid %0d model_pick %0d", issue_qid, exp_q);
        end
        if (sd >= 0) begin chk("done_to_issue_lat", sd, 2); sd = -1; end
      end
      if (issue_valid) chk("issue_qid", {21'd0, issue_qid}, int'(qid_base) + exp_q);
      prev_mc = mc;
      prev_valid = issue_valid;
      if (soft_clr) begin m_reset(); continue; end
      if (mdone && !enable) begin mdone = 0; msent = 0; end
      if (minfl && pkt_done) begin
        msent++; minfl = 0;
        if (num_pkt != 0 && msent == int'(num_pkt)) mdone = 1;
        else if (chk_lat && enable) sd = 0;
      end
      hs = issue_valid && issue_ready;
      if (hs) begin
        minfl = 1; iss_log.push_back(int'(issue_qid));
        mptr = (exp_q + 1) % nq;
      end
      d = int'(credit_qid) - int'(qid_base);
      for (int i = 0; i < MAX_Q; i++) begin
        v = mc[i];
        if (credit_updt && d >= 0 && d < nq && d == i) v += int'(credit_in);
        if (hs && i == exp_q) v -= pp;
        mc[i] = (v > CMAX) ? CMAX : (v < 0) ? 0 : v;
      end
    end
  end

  // Generator stand-in: pkt_done gen_delay cycles after each accepted request.
  initial forever begin
    @(posedge axi_aclk);
    if (axi_aresetn && issue_valid && issue_ready) begin
      repeat (gen_delay - 1) @(posedge axi_aclk);
      #1 pkt_done = 1;
      @(posedge axi_aclk);
      #1 pkt_done = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge axi_aclk);
    #1;
  endtask

  task automatic credit(input int qid, input int amt);
    credit_qid = QW'(qid); credit_in = 16'(amt); credit_updt = 1;
    tick();
    credit_updt = 0;
  endtask

  task automatic sclr();
    soft_clr = 1; tick(); soft_clr = 0;
  endtask

  task automatic wait_for_done(input int budget);
    int n = 0;
    while (!sched_done && n < budget) begin tick(); n++; end
    chk("done_reached", {31'd0, sched_done}, 1);
  endtask

  task automatic chk_log(input string nm, input int exp[$]);
    chk({nm, "_count"}, iss_log.size(), exp.size());
    foreach (exp[i]) if (i < iss_log.size()) chk($sformatf("%s_qid%0d", nm, i), iss_log[i], exp[i]);
    iss_log.delete();
  endtask

  initial begin
    int rr_exp[$] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int q0_exp[$] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int q2_exp[$] = '{2, 2, 2, 2};
    tick(2);
    chk("rst_issue_valid", {31'd0, issue_valid}, 0);
    chk("rst_issue_qid", {21'd0, issue_qid}, 0);
    chk("rst_busy", {31'd0, sched_busy}, 0);
    chk("rst_done", {31'd0, sched_done}, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    axi_aresetn = 1;
    tick();

    // Single queue, 8 packets
    num_queue = 1; qid_base = 0; num_pkt = 8; credit_perpkt_in = 1; issue_ready = 1;
    credit(0, 8);
    chk_lat = 1; enable = 1;
    tick();
    chk("en_lat_c1_valid", {31'd0, issue_valid}, 0);
    chk("en_lat_c1_busy", {31'd0, sched_busy}, 1);
    tick();
    chk("en_lat_c2_valid", {31'd0, issue_valid}, 1);
    wait_for_done(300);
    chk_log("single", q0_exp);
    chk("single_pkt_sent", pkt_sent, 8);
    chk("single_credit0", {16'd0, dut.credit[0]}, 0);
    enable = 0; tick(2);
    chk("done_clear", {31'd0, sched_done}, 0);
    chk("done_pkt_sent_clear", pkt_sent, 0);

    // Round robin over 4 queues
    sclr();
    num_queue = 4;
    for (int q = 0; q < 4; q++) credit(q, 4);
    enable = 1;
    wait_for_done(400);
    chk_log("rr", rr_exp);
    enable = 0; tick(2);

    // Skip queues without credit
    sclr(); chk_lat = 0;
    credit(2, 4); num_pkt = 4; enable = 1;
    wait_for_done(300);
    chk_log("skip", q2_exp);
    enable = 0; tick(2);

    // Starve in PICK, then a single credit releases one issue under backpressure
    num_pkt = 1; issue_ready = 0; enable = 1;
    tick(20);
    chk("starve_valid", {31'd0, issue_valid}, 0);
    chk("starve_busy", {31'd0, sched_busy}, 1);
    credit(1, 1);
    chk("late_credit_c1", {31'd0, issue_valid}, 0);
    tick();
    chk("late_credit_c2", {31'd0, issue_valid}, 1);
    chk("late_credit_qid", {21'd0, issue_qid}, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", {31'd0, issue_valid}, 1);
      chk("bp_qid", {21'd0, issue_qid}, 1);
      chk("bp_no_deduct", {16'd0, dut.credit[1]}, 1);
    end
    issue_ready = 1; tick();
    chk("bp_deduct", {16'd0, dut.credit[1]}, 0);
    chk("bp_valid_drop", {31'd0, issue_valid}, 0);
    wait_for_done(50);
    enable = 0; tick(2);

    // Boundaries: out-of-range ids, saturation, clamp, same-cycle net update
    sclr();
    qid_base = 4; num_queue = 2;
    credit(6, 7); credit(3, 7);
    credit(5, 16'hFFF0); credit(5, 16'hFFFF);
    chk("sat_credit1", {16'd0, dut.credit[1]}, 32'hFFFF);
    chk("oob_credit0", {16'd0, dut.credit[0]}, 0);
    chk("oob_credit2", {16'd0, dut.credit[2]}, 0);
    num_queue = 20;
    credit(11, 9); credit(12, 9);
    chk("clamp_credit7", {16'd0, dut.credit[7]}, 9);
    chk("clamp_wrap_credit0", {16'd0, dut.credit[0]}, 0);
    sclr();
    num_queue = 2; credit(4, 3); credit_perpkt_in = 2; issue_ready = 0; enable = 1;
    tick(2);
    chk("same_valid", {31'd0, issue_valid}, 1);
    chk("same_qid", {21'd0, issue_qid}, 4);
    issue_ready = 1;
    credit(4, 5);
    chk("same_cycle_net", {16'd0, dut.credit[0]}, 6);
    wait_for_done(50);
    enable = 0; tick(2);

    // Abort during WAIT, then async reset in ISSUE
    sclr();
    qid_base = 0; credit_perpkt_in = 0; num_pkt = 0;
    credit(0, 5); credit(1, 5);
    enable = 1; tick(3);
    enable = 0; tick();
    chk("abort_wait_busy", {31'd0, sched_busy}, 1);
    tick(12);
    chk("abort_idle_busy", {31'd0, sched_busy}, 0);
    chk("abort_valid", {31'd0, issue_valid}, 0);
    chk("abort_pkt_sent", pkt_sent, 1);
    issue_ready = 0; enable = 1; tick(2);
    chk("pre_rst_valid", {31'd0, issue_valid}, 1);
    #2 axi_aresetn = 0;
    #1;
    chk("rst_mid_valid", {31'd0, issue_valid}, 0);
    chk("rst_mid_busy", {31'd0, sched_busy}, 0);
    chk("rst_mid_pkt_sent", pkt_sent, 0);
    chk("rst_mid_credit0", {16'd0, dut.credit[0]}, 0);
    chk("rst_mid_credit1", {16'd0, dut.credit[1]}, 0);
    enable = 0; issue_ready = 1;
    tick();
    axi_aresetn = 1;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
